cp0_unit: RTL and testbench

Coprocessor-0 unit for the single-cycle MIPS CPU. It is the responder to the next-PC logic: it raises `hasexp` and supplies `cp0_pcout`, which is the exception vector on entry and the saved EPC on `eret`. It holds Status, Cause, EPC, Count and Compare, services `mtc0`/`mfc0`, and generates the timer interrupt.

---
 rtl/cp0_unit_if.sv | 38 +++
 rtl/cp0_unit.sv | 209 ++++++++++++++++++++
 tb/tb_cp0_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_unit_if.sv
// ---------------------------------------------------------------------------
// cp0_unit_if
// Bundles the signals exchanged between the CPU datapath/next-PC logic and
// the coprocessor-0 unit.
//   present_pc  PC of the instruction executing this cycle
//   mtc0        write CP0 register cp0_addr with wdata
//   cp0_addr    register select (9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC)
//   wdata       mtc0 write data
//   rdata       mfc0 read data (combinational)
//   iseret      current instruction is eret
//   syscall/ri/ov  synchronous exception flags
//   hasexp      take exception this cycle (combinational)
//   cp0_pcout   redirect target: exception vector or saved EPC
// master = CPU side, slave = CP0 side.
// ---------------------------------------------------------------------------
interface cp0_unit_if;
   logic [31:0] present_pc;
   logic        mtc0;
   logic [4:0]  cp0_addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        iseret;
   logic        syscall;
   logic        ri;
   logic        ov;
   logic        hasexp;
   logic [31:0] cp0_pcout;

   modport master (
      output present_pc, mtc0, cp0_addr, wdata, iseret, syscall, ri, ov,
      input  rdata, hasexp, cp0_pcout
   );

   modport slave (
      input  present_pc, mtc0, cp0_addr, wdata, iseret, syscall, ri, ov,
      output rdata, hasexp, cp0_pcout
   );
endinterface

// File: rtl/cp0_unit.sv
// ---------------------------------------------------------------------------
// cp0_unit
// Coprocessor-0 for the single-cycle MIPS CPU: Status, Cause, EPC, Count and
// Compare registers, mtc0/mfc0 access, exception entry/return and the timer
// interrupt.
// Ports:
//   clk       system clock, state updates on rising edge
//   rst_n     asynchronous active-low reset
//   bus       cp0_unit_if.slave (PC, mtc0/mfc0, eret, exception flags,
//             hasexp, cp0_pcout)
//   int_req   level hardware interrupt lines
//   status, cause, epc  register values for debug
// ---------------------------------------------------------------------------
module cp0_unit #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0400
) (
   input  logic              clk,
   input  logic              rst_n,
   cp0_unit_if.slave         bus,
   input  logic [5:0]        int_req,
   output logic [31:0]       status,
   output logic [31:0]       cause,
   output logic [31:0]       epc
);

   localparam logic [4:0] ADDR_COUNT   = 5'd9;
   localparam logic [4:0] ADDR_COMPARE = 5'd11;
   localparam logic [4:0] ADDR_STATUS  = 5'd12;
   localparam logic [4:0] ADDR_CAUSE   = 5'd13;
   localparam logic [4:0] ADDR_EPC     = 5'd14;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;
   localparam logic [4:0] EXC_SYS = 5'd8;

   // Winning exception code: Int > RI > Ov > Sys.
   function automatic logic [4:0] exc_code_f(
      input logic int_pend,
      input logic ri_flag,
      input logic ov_flag
   );
      logic [4:0] code;
      if (int_pend) begin
         code = EXC_INT;
      end else if (ri_flag) begin
         code = EXC_RI;
      end else if (ov_flag) begin
         code = EXC_OV;
      end else begin
         code = EXC_SYS;
      end
      return code;
   endfunction

   logic        ie_r;
   logic        exl_r;
   logic [7:0]  im_r;
   logic [1:0]  ip_sw_r;
   logic [4:0]  exc_code_r;
   logic [31:0] epc_r;
   logic [31:0] count_r;
   logic [31:0] compare_r;
   logic        timer_pend_r;

   logic [7:0]  ip_s;
   logic [31:0] status_s;
   logic [31:0] cause_s;
   logic        int_pend_s;
   logic        hasexp_s;
   logic        eret_s;
   logic        wr_en_s;
   logic        wr_count_s;
   logic        wr_compare_s;
   logic        wr_status_s;
   logic        wr_cause_s;
   logic        wr_epc_s;
   logic        ie_nxt_s;
   logic        exl_nxt_s;
   logic [7:0]  im_nxt_s;
   logic [31:0] rdata_s;

   // Register views, pending interrupt and exception/eret/write qualifiers.
   always_comb begin
      // IP[7] merges the timer into hardware line 5; IP[1:0] are software bits.
      ip_s       = {int_req[5] | timer_pend_r, int_req[4:0], ip_sw_r};
      status_s   = {16'h0000, im_r, 6'b00_0000, exl_r, ie_r};
      cause_s    = {16'h0000, ip_s, 1'b0, exc_code_r, 2'b00};
      int_pend_s = ie_r & ~exl_r & (|(ip_s & im_r));
      hasexp_s   = int_pend_s | bus.ri | bus.ov | bus.syscall;
      // Exception entry overrides both eret and any same-cycle mtc0.
      eret_s       = bus.iseret & ~hasexp_s;
      wr_en_s      = bus.mtc0 & ~hasexp_s;
      wr_count_s   = wr_en_s & (bus.cp0_addr == ADDR_COUNT);
      wr_compare_s = wr_en_s & (bus.cp0_addr == ADDR_COMPARE);
      wr_status_s  = wr_en_s & (bus.cp0_addr == ADDR_STATUS);
      wr_cause_s   = wr_en_s & (bus.cp0_addr == ADDR_CAUSE);
      wr_epc_s     = wr_en_s & (bus.cp0_addr == ADDR_EPC);
   end

   // Next Status fields: entry sets EXL, otherwise mtc0 then eret.
   always_comb begin
      ie_nxt_s  = ie_r;
      exl_nxt_s = exl_r;
      im_nxt_s  = im_r;
      if (hasexp_s) begin
         exl_nxt_s = 1'b1;
      end else begin
         if (wr_status_s) begin
            ie_nxt_s  = bus.wdata[0];
            exl_nxt_s = bus.wdata[1];
            im_nxt_s  = bus.wdata[15:8];
         end else begin
            im_nxt_s = im_r;
         end
         if (eret_s) begin
            exl_nxt_s = 1'b0;
         end else begin
            ie_nxt_s = ie_nxt_s;
         end
      end
   end

   // mfc0 read mux over pre-edge register values.
   always_comb begin
      rdata_s = 32'h0000_0000;
      case (bus.cp0_addr)
         ADDR_COUNT:   rdata_s = count_r;
         ADDR_COMPARE: rdata_s = compare_r;
         ADDR_STATUS:  rdata_s = status_s;
         ADDR_CAUSE:   rdata_s = cause_s;
         ADDR_EPC:     rdata_s = epc_r;
         default:      rdata_s = 32'h0000_0000;
      endcase
   end

   assign bus.rdata     = rdata_s;
   assign bus.hasexp    = hasexp_s;
   assign bus.cp0_pcout = eret_s ? epc_r : EXC_VECTOR;
   assign status        = status_s;
   assign cause         = cause_s;
   assign epc           = epc_r;

   // Status register fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie_r  <= 1'b0;
         exl_r <= 1'b0;
         im_r  <= 8'h00;
      end else begin
         ie_r  <= ie_nxt_s;
         exl_r <= exl_nxt_s;
         im_r  <= im_nxt_s;
      end
   end

   // Cause ExcCode and software interrupt bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_code_r <= 5'd0;
         ip_sw_r    <= 2'b00;
      end else begin
         if (hasexp_s) begin
            exc_code_r <= exc_code_f(int_pend_s, bus.ri, bus.ov);
         end
         if (wr_cause_s) begin
            ip_sw_r <= bus.wdata[9:8];
         end
      end
   end

   // EPC: captured only on first-level entry so nested faults keep the return PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epc_r <= 32'h0000_0000;
      end else if (hasexp_s) begin
         if (!exl_r) begin
            epc_r <= bus.present_pc;
         end
      end else if (wr_epc_s) begin
         epc_r <= bus.wdata;
      end
   end

   // Count free-runs; a write replaces that cycle's increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= 32'h0000_0000;
      end else if (wr_count_s) begin
         count_r <= bus.wdata;
      end else begin
         count_r <= count_r + 32'd1;
      end
   end

   // Compare and timer pending; a Compare write clears and beats a same-cycle match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         compare_r    <= 32'hFFFF_FFFF;
         timer_pend_r <= 1'b0;
      end else if (wr_compare_s) begin
         compare_r    <= bus.wdata;
         timer_pend_r <= 1'b0;
      end else if (count_r == compare_r) begin
         timer_pend_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
// ---------------------------------------------------------------------------
// tb_cp0_unit
// Directed scenarios followed by a randomized phase, every cycle compared
// against a word-level reference model of the CP0 registers.
// ---------------------------------------------------------------------------
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  int_req;
   logic [31:0] status;
   logic [31:0] cause;
   logic [31:0] epc;

   cp0_unit_if bus ();

   cp0_unit #(.EXC_VECTOR(32'h0000_0400)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .int_req (int_req),
      .status  (status),
      .cause   (cause),
      .epc     (epc)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state (whole register words)
   logic [31:0] m_status;
   logic [1:0]  m_sw;
   logic [4:0]  m_exc;
   logic [31:0] m_epc;
   logic [31:0] m_count;
   logic [31:0] m_compare;
   logic        m_tp;

   // model predictions for the current cycle
   logic        e_hasexp;
   logic [4:0]  e_code;
   logic [31:0] e_pcout;
   logic [31:0] e_rdata;
   logic [31:0] e_cause;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_status  = 32'h0;
      m_sw      = 2'b00;
      m_exc     = 5'd0;
      m_epc     = 32'h0;
      m_count   = 32'h0;
      m_compare = 32'hFFFF_FFFF;
      m_tp      = 1'b0;
   endtask

   task automatic model_eval();
      logic [7:0] ip;
      logic       pend;
      ip      = {int_req[5] | m_tp, int_req[4:0], m_sw};
      e_cause = {16'h0, ip, 1'b0, m_exc, 2'b00};
      pend    = m_status[0] && !m_status[1] && ((ip & m_status[15:8]) != 8'h00);
      e_hasexp = pend || bus.ri || bus.ov || bus.syscall;
      if (pend)         e_code = 5'd0;
      else if (bus.ri)  e_code = 5'd10;
      else if (bus.ov)  e_code = 5'd12;
      else              e_code = 5'd8;
      e_pcout = (bus.iseret && !e_hasexp) ? m_epc : 32'h0000_0400;
      case (bus.cp0_addr)
         5'd9:    e_rdata = m_count;
         5'd11:   e_rdata = m_compare;
         5'd12:   e_rdata = m_status;
         5'd13:   e_rdata = e_cause;
         5'd14:   e_rdata = m_epc;
         default: e_rdata = 32'h0;
      endcase
   endtask

   task automatic model_update();
      logic [31:0] cnt_next;
      logic        cmp_wr;
      logic        match;
      if (!rst_n) begin
         model_reset();
      end else begin
         model_eval();
         cnt_next = m_count + 32'd1;
         cmp_wr   = 1'b0;
         match    = (m_count == m_compare);
         if (e_hasexp) begin
            m_exc = e_code;
            if (!m_status[1]) begin
               m_epc       = bus.present_pc;
               m_status[1] = 1'b1;
            end
         end else begin
            if (bus.mtc0) begin
               case (bus.cp0_addr)
                  5'd9:  cnt_next = bus.wdata;
                  5'd11: begin m_compare = bus.wdata; cmp_wr = 1'b1; end
                  5'd12: m_status = bus.wdata & 32'h0000_FF03;
                  5'd13: m_sw = bus.wdata[9:8];
                  5'd14: m_epc = bus.wdata;
                  default: ;
               endcase
            end
            if (bus.iseret) m_status[1] = 1'b0;
         end
         if (cmp_wr)     m_tp = 1'b0;
         else if (match) m_tp = 1'b1;
         m_count = cnt_next;
      end
   endtask

   // Called at a negedge with inputs already driven: compare, clock, advance model.
   task automatic tick();
      #1;
      model_eval();
      check32("hasexp",    {31'h0, bus.hasexp}, {31'h0, e_hasexp});
      check32("cp0_pcout", bus.cp0_pcout, e_pcout);
      check32("rdata",     bus.rdata, e_rdata);
      check32("status",    status, m_status);
      check32("cause",     cause, e_cause);
      check32("epc",       epc, m_epc);
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.present_pc = 32'h0;
      bus.mtc0       = 1'b0;
      bus.cp0_addr   = 5'd0;
      bus.wdata      = 32'h0;
      bus.iseret     = 1'b0;
      bus.syscall    = 1'b0;
      bus.ri         = 1'b0;
      bus.ov         = 1'b0;
      int_req        = 6'h00;
   endtask

   task automatic do_mtc0(input logic [4:0] addr, input logic [31:0] data);
      bus.mtc0     = 1'b1;
      bus.cp0_addr = addr;
      bus.wdata    = data;
      tick();
      bus.mtc0     = 1'b0;
   endtask

   initial begin
      int n;
      logic [31:0] r;
      logic [2:0]  pick;

      // ---------------- reset with random data inputs ----------------
      idle();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         r = $urandom;
         bus.present_pc = $urandom;
         bus.wdata      = $urandom;
         bus.mtc0       = r[0];
         bus.cp0_addr   = r[8:4];
         #1;
         check32("rst_hasexp", {31'h0, bus.hasexp}, 32'h0);
         check32("rst_pcout",  bus.cp0_pcout, 32'h0000_0400);
         check32("rst_status", status, 32'h0);
         check32("rst_cause",  cause, 32'h0);
         check32("rst_epc",    epc, 32'h0);
         tick();
      end
      idle();
      rst_n = 1'b1;
      bus.cp0_addr = 5'd9;
      tick();
      for (int k = 1; k <= 3; k++) begin
         #1;
         check32("count_after_rst", bus.rdata, k);
         tick();
      end

      // ---------------- syscall entry and eret ----------------
      bus.present_pc = 32'h0000_0040;
      bus.syscall    = 1'b1;
      #1;
      check32("sys_hasexp", {31'h0, bus.hasexp}, 32'h1);
      check32("sys_pcout",  bus.cp0_pcout, 32'h0000_0400);
      tick();
      idle();
      check32("sys_epc",  epc, 32'h0000_0040);
      check32("sys_exl",  {31'h0, status[1]}, 32'h1);
      check32("sys_code", {27'h0, cause[6:2]}, 32'd8);
      bus.iseret = 1'b1;
      #1;
      check32("eret_pcout", bus.cp0_pcout, 32'h0000_0040);
      tick();
      idle();
      check32("eret_exl", {31'h0, status[1]}, 32'h0);

      // ---------------- nested exception keeps EPC ----------------
      bus.present_pc = 32'h0000_0040;
      bus.syscall    = 1'b1;
      tick();
      idle();
      bus.present_pc = 32'h0000_0404;
      bus.ov         = 1'b1;
      tick();
      idle();
      check32("nest_epc",  epc, 32'h0000_0040);
      check32("nest_code", {27'h0, cause[6:2]}, 32'd12);
      bus.iseret = 1'b1;
      tick();
      idle();

      // ---------------- interrupt masking ----------------
      do_mtc0(5'd12, 32'h0000_0401);
      bus.present_pc = 32'h0000_0080;
      int_req = 6'h01;
      #1;
      check32("int_hasexp", {31'h0, bus.hasexp}, 32'h1);
      tick();
      check32("int_code", {27'h0, cause[6:2]}, 32'd0);
      check32("int_epc",  epc, 32'h0000_0080);
      bus.iseret = 1'b1;                 // int_req still held, EXL=1
      #1;
      check32("eret_int_hasexp", {31'h0, bus.hasexp}, 32'h0);
      check32("eret_int_pcout",  bus.cp0_pcout, 32'h0000_0080);
      tick();
      idle();
      do_mtc0(5'd12, 32'h0000_0001);
      int_req = 6'h01;
      #1;
      check32("int_masked", {31'h0, bus.hasexp}, 32'h0);
      tick();
      do_mtc0(5'd12, 32'h0000_0403);
      #1;
      check32("int_exl_masked", {31'h0, bus.hasexp}, 32'h0);
      tick();
      idle();
      bus.iseret = 1'b1;
      tick();
      idle();

      // ---------------- timer ----------------
      do_mtc0(5'd12, 32'h0000_8001);
      do_mtc0(5'd9,  32'h0000_0000);
      do_mtc0(5'd11, 32'h0000_0005);
      bus.cp0_addr = 5'd9;
      n = 0;
      while (n < 20) begin
         #1;
         if (bus.hasexp) break;
         tick();
         n++;
      end
      check32("timer_latency", n, 32'd5);
      check32("timer_ip7", {31'h0, cause[15]}, 32'h1);
      tick();
      do_mtc0(5'd11, 32'h0000_0100);
      check32("timer_clear", {31'h0, cause[15]}, 32'h0);
      bus.iseret = 1'b1;
      tick();
      idle();

      // ---------------- simultaneous mtc0 and ri ----------------
      bus.mtc0     = 1'b1;
      bus.cp0_addr = 5'd12;
      bus.wdata    = 32'h0000_0001;
      bus.ri       = 1'b1;
      tick();
      idle();
      check32("sim_status", status, 32'h0000_8003);
      check32("sim_code",   {27'h0, cause[6:2]}, 32'd10);
      bus.iseret = 1'b1;
      tick();
      idle();

      // ---------------- Count wrap ----------------
      do_mtc0(5'd9, 32'hFFFF_FFFF);
      #1;
      check32("wrap_max", bus.rdata, 32'hFFFF_FFFF);
      tick();
      check32("wrap_zero", bus.rdata, 32'h0);

      // ---------------- reset in the middle of an exception ----------------
      bus.present_pc = 32'h0000_0200;
      bus.syscall    = 1'b1;
      tick();
      bus.syscall    = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check32("mid_rst_status",  status, 32'h0);
      check32("mid_rst_epc",     epc, 32'h0);
      check32("mid_rst_cause",   cause, 32'h0);
      check32("mid_rst_count",   bus.rdata, 32'h0);
      bus.cp0_addr = 5'd11;
      #1;
      check32("mid_rst_compare", bus.rdata, 32'hFFFF_FFFF);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      tick();

      // ---------------- randomized phase ----------------
      for (int i = 0; i < 400; i++) begin
         r = $urandom;
         bus.present_pc = $urandom;
         bus.mtc0       = (r[1:0] == 2'b00);
         pick           = r[4:2];
         case (pick)
            3'd0:    bus.cp0_addr = 5'd9;
            3'd1:    bus.cp0_addr = 5'd11;
            3'd2:    bus.cp0_addr = 5'd12;
            3'd3:    bus.cp0_addr = 5'd13;
            3'd4:    bus.cp0_addr = 5'd14;
            3'd5:    bus.cp0_addr = 5'd0;
            3'd6:    bus.cp0_addr = 5'd8;
            default: bus.cp0_addr = 5'd31;
         endcase
         bus.wdata   = r[5] ? $urandom : $urandom_range(0, 20);
         bus.iseret  = !bus.mtc0 && (r[8:6] == 3'b000);
         bus.ri      = (r[12:9] == 4'h0);
         bus.ov      = (r[16:13] == 4'h0);
         bus.syscall = (r[20:17] == 4'h0);
         int_req     = (r[22:21] == 2'b00) ? r[28:23] : 6'h00;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
